dbg_trace_buffer: RTL and testbench
===================================

# dbg_trace_buffer

Captures the CPU's per-step debug record (dbg_inst, dbg_a, dbg_b, dbg_op) into a small FIFO and plays it back byte-by-byte on the 8-bit LED bank under SEL control. It sits beside the experiment CPU top as the receiving end of the debug port that the CPU drives. Board switches and buttons inspect a recorded instruction history after the fact instead of watching live signals.

## Interface
- DEPTH_LOG2, 3, log2 of the FIFO depth in records; the default gives 8 records.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- cap_en  in  1  one-cycle strobe from the CPU: the debug inputs hold a valid record this cycle.
- dbg_inst  in  32  instruction word of the captured step.
- dbg_a  in  32  ALU operand A.
- dbg_b  in  32  ALU operand B.
- dbg_op  in  3  ALU operation code.
- rd_next  in  1  one-cycle pulse from a debounced button; pops the head record.
- SEL  in  3  byte selector for LED.
- LED  out  8  registered view of the selected byte.
- empty  out  1  high when count == 0.
- full  out  1  high when count == 2^DEPTH_LOG2.
- count  out  DEPTH_LOG2+1  number of stored records.
- overflow  out  1  sticky flag: a capture was dropped.

## Operation
- Storage: 2^DEPTH_LOG2 records of 99 bits each ({op, b, a, inst}).
- Storage uses write pointer wp and read pointer rp, each DEPTH_LOG2 bits, both wrapping modulo depth.
- Write: when cap_en=1 and (full=0 or a pop happens in the same cycle), store the record at wp, then wp+1.
- Drop: when cap_en=1, full=1 and rd_next=0, discard the record and set overflow=1. Only RST clears overflow.
- Pop: when rd_next=1 and empty=0, rp+1. A pop while empty is ignored, with no underflow flag.
- Simultaneous cap_en and rd_next:
  - Not empty and not full: both happen; count is unchanged.
  - Full: both happen; no drop, count stays at full.
  - Empty: only the write happens; count becomes 1.
- LED mux source is the head record (rp) and SEL:
  - 0: inst[7:0]
  - 1: inst[15:8]
  - 2: inst[23:16]
  - 3: inst[31:24]
  - 4: a[7:0]
  - 5: b[7:0]
  - 6: {5'b0, op}
  - 7: {overflow, count zero-extended to 7 bits}
- When empty=1, SEL 0–6 show 8'h00. SEL 7 always shows the flag/count byte.
- Reset: wp=0, rp=0, count=0, overflow=0, LED=8'h00, empty=1, full=0. Stored record contents need not be cleared.
- Reset during activity: RST wins over cap_en and rd_next in the same cycle. Nothing is written or popped.

## Timing
- count, empty, full and overflow are registered and reflect an edge's action immediately after that edge.
- LED is loaded every rising edge from the mux, using SEL and the head/count/overflow values present before the edge.
- So LED reflects a SEL change one cycle later.
- A pop at edge N shows the new head on LED from edge N+1. The same applies to the first capture into an empty FIFO.
- Capture latency: a record strobed at edge N is readable as head (if it is the oldest) and appears on LED at edge N+1.
- The cap_en and rd_next input paths are single-cycle, with no throughput limit: one capture and one pop may occur every cycle.

## Test plan
- Reset: assert RST for 2 cycles with cap_en=1 held.
  - Expected: count=0, empty=1, full=0, overflow=0, LED=8'h00; nothing captured.
- Capture 3 records (inst=32'h01234567, 32'h89ABCDEF, 32'h0000001F), then SEL=3.
  - Expected: LED=8'h01 one cycle later.
  - Pop once, SEL=0: LED=8'hEF.
  - SEL=7: LED=8'h02.
- Fill with 8 captures, then one more with rd_next=0.
  - Expected: full=1, count=8, overflow=1.
  - Expected: head inst is still the first record; the ninth record is not stored.
- With FIFO full, pulse cap_en and rd_next together (inst=32'hDEADBEEF).
  - Expected: count stays 8, overflow unchanged.
  - After 7 further pops: head inst=32'hDEADBEEF.
- With FIFO empty, pulse rd_next alone.
  - Expected: count stays 0, LED (SEL=0)=8'h00.
  - Then cap_en and rd_next together: count=1.
- Capture 5 records, pop 2, assert RST for 1 cycle.
  - Expected: count=0, overflow=0, LED=8'h00.
  - A subsequent capture reads back correctly at SEL 0–6, confirming the pointers restarted at 0.

Source files
------------

// File: rtl/dbg_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_trace_buffer
//  Description : Captures per-step CPU debug records {op, b, a, inst} into a
//                small FIFO and plays the head record back one byte at a time
//                on an 8-bit LED bank, selected by SEL.
//  Ports       : CLK, RST (sync, active high)
//                cap_en, dbg_inst, dbg_a, dbg_b, dbg_op : capture side
//                rd_next                                : pop the head record
//                SEL -> LED                             : byte viewer
//                empty, full, count, overflow           : FIFO status
//  Revision    : 1.0  initial release
// ============================================================================
module dbg_trace_buffer #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cap_en,
    input  logic [31:0]           dbg_inst,
    input  logic [31:0]           dbg_a,
    input  logic [31:0]           dbg_b,
    input  logic [2:0]            dbg_op,
    input  logic                  rd_next,
    input  logic [2:0]            SEL,
    output logic [7:0]            LED,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  c_REC_W    = 99;
    localparam logic [DEPTH_LOG2:0] c_FULL_CNT = c_DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = 1;

    // Record storage; contents are deliberately not reset.
    logic [c_REC_W-1:0]    r_mem [c_DEPTH];

    logic [DEPTH_LOG2-1:0] r_wp_q, w_wp_d;
    logic [DEPTH_LOG2-1:0] r_rp_q, w_rp_d;
    logic [DEPTH_LOG2:0]   r_count_q, w_count_d;
    logic                  r_empty_q, w_empty_d;
    logic                  r_full_q, w_full_d;
    logic                  r_overflow_q, w_overflow_d;
    logic [7:0]            r_led_q, w_led_d;

    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic [c_REC_W-1:0]    w_head;
    logic [c_REC_W-1:0]    w_record;
    logic                  w_unused;

    assign w_record = {dbg_op, dbg_b, dbg_a, dbg_inst};
    assign w_head   = r_mem[r_rp_q];
    // Upper operand bits are stored but never shown on the LED bank.
    assign w_unused = ^{w_head[95:72], w_head[63:40]};

    always_comb begin
        // A pop while full frees the slot the same-cycle capture needs.
        w_pop        = rd_next & ~r_empty_q;
        w_wr         = cap_en & (~r_full_q | w_pop);
        w_drop       = cap_en & r_full_q & ~rd_next;

        w_wp_d       = w_wr  ? r_wp_q + c_PTR_ONE : r_wp_q;
        w_rp_d       = w_pop ? r_rp_q + c_PTR_ONE : r_rp_q;

        w_count_d    = r_count_q;
        if (w_wr && !w_pop) begin
            w_count_d = r_count_q + c_CNT_ONE;
        end else if (w_pop && !w_wr) begin
            w_count_d = r_count_q - c_CNT_ONE;
        end

        w_empty_d    = (w_count_d == '0);
        w_full_d     = (w_count_d == c_FULL_CNT);
        w_overflow_d = r_overflow_q | w_drop;

        // Viewer mux uses pre-edge head/status; record bytes blank when empty.
        w_led_d = 8'h00;
        if (SEL == 3'd7) begin
            w_led_d = {r_overflow_q, 7'(r_count_q)};
        end else if (!r_empty_q) begin
            case (SEL)
                3'd0:    w_led_d = w_head[7:0];
                3'd1:    w_led_d = w_head[15:8];
                3'd2:    w_led_d = w_head[23:16];
                3'd3:    w_led_d = w_head[31:24];
                3'd4:    w_led_d = w_head[39:32];
                3'd5:    w_led_d = w_head[71:64];
                3'd6:    w_led_d = {5'b0, w_head[98:96]};
                default: w_led_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp_q       <= '0;
            r_rp_q       <= '0;
            r_count_q    <= '0;
            r_empty_q    <= 1'b1;
            r_full_q     <= 1'b0;
            r_overflow_q <= 1'b0;
            r_led_q      <= 8'h00;
        end else begin
            r_wp_q       <= w_wp_d;
            r_rp_q       <= w_rp_d;
            r_count_q    <= w_count_d;
            r_empty_q    <= w_empty_d;
            r_full_q     <= w_full_d;
            r_overflow_q <= w_overflow_d;
            r_led_q      <= w_led_d;
        end
    end

    // Reset suppresses a same-cycle write.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr) begin
            r_mem[r_wp_q] <= w_record;
        end
    end

    assign LED      = r_led_q;
    assign empty    = r_empty_q;
    assign full     = r_full_q;
    assign count    = r_count_q;
    assign overflow = r_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dbg_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbg_trace_buffer
//  Description : Directed self-checking bench for dbg_trace_buffer. A queue
//                of expected records tracks what the FIFO should hold; it is
//                pushed on capture and popped on read, and every LED/status
//                observation is compared against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dbg_trace_buffer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cap_en = 1'b0;
    logic [31:0] dbg_inst = '0;
    logic [31:0] dbg_a = '0;
    logic [31:0] dbg_b = '0;
    logic [2:0]  dbg_op = '0;
    logic        rd_next = 1'b0;
    logic [2:0]  SEL = '0;
    logic [7:0]  LED;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;

    logic [98:0] mq [$];
    logic        m_ovf = 1'b0;

    dbg_trace_buffer #(.DEPTH_LOG2(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cap_en   (cap_en),
        .dbg_inst (dbg_inst),
        .dbg_a    (dbg_a),
        .dbg_b    (dbg_b),
        .dbg_op   (dbg_op),
        .rd_next  (rd_next),
        .SEL      (SEL),
        .LED      (LED),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_led(input logic [2:0] s);
        logic [98:0] h;
        if (s == 3'd7) return {m_ovf, 7'(mq.size())};
        if (mq.size() == 0) return 8'h00;
        h = mq[0];
        case (s)
            3'd0:    return h[7:0];
            3'd1:    return h[15:8];
            3'd2:    return h[23:16];
            3'd3:    return h[31:24];
            3'd4:    return h[39:32];
            3'd5:    return h[71:64];
            default: return {5'b0, h[98:96]};
        endcase
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(mq.size() == 8));
        chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    endtask

    // One clock with the given capture/pop strobes; model follows the FIFO rules.
    task automatic step(input logic cap, input logic rd, input logic [31:0] inst,
                        input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bit pop, wr;
        @(negedge CLK);
        cap_en = cap; rd_next = rd;
        dbg_inst = inst; dbg_a = a; dbg_b = b; dbg_op = op;
        @(posedge CLK);
        #1;
        pop = rd && (mq.size() > 0);
        wr  = cap && ((mq.size() < 8) || pop);
        if (cap && mq.size() == 8 && !rd) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (wr)  mq.push_back({op, b, a, inst});
    endtask

    task automatic cap(input logic [31:0] inst);
        step(1'b1, 1'b0, inst, inst ^ 32'h5A5A_0033, ~inst, inst[2:0] ^ 3'd5);
    endtask

    task automatic pop();
        step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 3'd0);
    endtask

    // Set SEL, idle one edge, then compare LED with the model's view.
    task automatic check_led(input logic [2:0] s, input string tag);
        @(negedge CLK);
        cap_en = 1'b0; rd_next = 1'b0; SEL = s;
        @(posedge CLK);
        #1;
        chk(tag, 32'(LED), 32'(exp_led(s)));
    endtask

    task automatic do_reset(input int n, input logic hold_cap);
        @(negedge CLK);
        RST = 1'b1; cap_en = hold_cap; rd_next = hold_cap;
        dbg_inst = 32'hCAFE_F00D;
        repeat (n) @(posedge CLK);
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk_state("rst");
        chk("rst.led", 32'(LED), 32'h00);
        @(negedge CLK);
        RST = 1'b0; cap_en = 1'b0; rd_next = 1'b0;
    endtask

    initial begin
        // Reset with capture held: nothing captured.
        do_reset(2, 1'b1);
        chk("rst.count0", 32'(count), 32'd0);

        // Three captures, view top byte of head, then pop and view.
        cap(32'h0123_4567);
        cap(32'h89AB_CDEF);
        cap(32'h0000_001F);
        chk_state("cap3");
        check_led(3'd3, "cap3.sel3");
        chk("cap3.sel3.lit", 32'(LED), 32'h01);
        pop();
        check_led(3'd0, "pop1.sel0");
        chk("pop1.sel0.lit", 32'(LED), 32'hEF);
        check_led(3'd7, "pop1.sel7");
        chk("pop1.sel7.lit", 32'(LED), 32'h02);
        for (int s = 4; s < 7; s++) check_led(3'(s), "pop1.selx");

        // Fill to 8, then a ninth capture is dropped.
        do_reset(1, 1'b0);
        for (int i = 0; i < 8; i++) cap(32'h1000_0000 + 32'(i * 32'h0101_0101));
        chk_state("fill8");
        cap(32'h9999_9999);
        chk_state("drop");
        chk("drop.ovf.lit", 32'(overflow), 32'd1);
        chk("drop.count.lit", 32'(count), 32'd8);
        for (int s = 0; s < 4; s++) check_led(3'(s), "drop.head");
        check_led(3'd7, "drop.sel7");
        chk("drop.sel7.lit", 32'(LED), 32'h88);

        // Full: capture + pop together, no drop.
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444, 3'd6);
        chk_state("fullboth");
        chk("fullboth.count.lit", 32'(count), 32'd8);
        for (int i = 0; i < 7; i++) pop();
        chk_state("pop7");
        begin
            logic [31:0] hi;
            for (int s = 0; s < 4; s++) begin
                check_led(3'(s), "beef.byte");
                hi[s*8 +: 8] = LED;
            end
            chk("beef.inst", hi, 32'hDEAD_BEEF);
        end
        check_led(3'd6, "beef.op");

        // Drain, then pop while empty, then capture + pop while empty.
        pop();
        chk_state("drained");
        pop();
        chk_state("emptypop");
        check_led(3'd0, "emptypop.sel0");
        chk("emptypop.sel0.lit", 32'(LED), 32'h00);
        step(1'b1, 1'b1, 32'h7777_ABCD, 32'h0000_00A5, 32'h0000_005A, 3'd3);
        chk_state("emptyboth");
        chk("emptyboth.count.lit", 32'(count), 32'd1);
        check_led(3'd0, "emptyboth.sel0");

        // Activity followed by reset; pointers restart.
        for (int i = 0; i < 5; i++) cap(32'h2000_0000 + 32'(i));
        pop();
        pop();
        chk_state("pre_rst");
        do_reset(1, 1'b0);
        cap(32'hA1B2_C3D4);
        for (int s = 0; s < 7; s++) check_led(3'(s), "post_rst.sel");
        chk_state("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
